// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_queue_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int PTR_W         = $clog2(DEPTH_DEFAULT);
  localparam int CNT_W         = PTR_W + 1;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        excp;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle; the queue takes the slave side
interface fetch_queue_if #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               flush;
  logic               push_valid;
  logic               push_ready;
  logic [PC_W-1:0]    push_pc;
  logic [INSTR_W-1:0] push_instr;
  logic               push_excp;
  logic               pop_valid;
  logic               pop_ready;
  logic [PC_W-1:0]    pop_pc;
  logic [INSTR_W-1:0] pop_instr;
  logic               pop_excp;
  logic [CNT_W-1:0]   count;
  logic               almost_full;

  modport master (
    output flush, push_valid, push_pc, push_instr, push_excp, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_instr, pop_excp, count, almost_full
  );

  modport slave (
    input  flush, push_valid, push_pc, push_instr, push_excp, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_instr, pop_excp, count, almost_full
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// rtl/fetch_queue_storage.sv - fq_storage: DEPTH x W register array, one write port, async read, no reset
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue with flush; FETCH_QUEUE_BYPASS_EN adds an empty-queue bypass
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int INSTR_W  = 32,
  parameter int PC_W     = 32,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INSTR_W + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          afull_q, afull_d;

  logic [EW-1:0] wr_entry, rd_entry, head_entry;
  logic          empty, push_fire, pop_fire, bypass, store_en, rd_adv;

  assign empty          = (count_q == '0);
  assign bus.push_ready = (count_q != CW'(DEPTH));
  assign push_fire      = bus.push_valid & bus.push_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  // rst gating keeps pop_valid low while reset is held even if fetch is pushing
  assign bypass = empty & push_fire & ~bus.flush & rst;
`else
  assign bypass = 1'b0;
`endif

  assign bus.pop_valid = ~bus.flush & (~empty | bypass);
  assign pop_fire      = bus.pop_valid & bus.pop_ready;

  // A bypassed entry taken by decode never touches storage or the pointers
  assign store_en = push_fire & ~(bypass & bus.pop_ready);
  assign rd_adv   = pop_fire & ~bypass;

  assign wr_entry = {bus.push_pc, bus.push_instr, bus.push_excp};

  always_comb begin
    head_entry = '0;
    if (!empty) begin
      head_entry = rd_entry;
    end else if (bypass) begin
      head_entry = wr_entry;
    end
  end

  assign {bus.pop_pc, bus.pop_instr, bus.pop_excp} = head_entry;
  assign bus.count       = count_q;
  assign bus.almost_full = afull_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_adv)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({store_en, rd_adv})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    afull_d = (count_d >= CW'(AFULL_TH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_storage (
    .clk     (clk),
    .we_i    (store_en & ~bus.flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (DEPTH=4, AFULL_TH=3)
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   vec = 0;
  int   err = 0;
  int   occ = 0;

  fq_entry_t exp_q[$];
  fq_entry_t mon_e;
  fq_entry_t sb_e;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .INSTR_W  (32),
    .PC_W     (32),
    .AFULL_TH (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic excp);
    bus.push_valid = 1'b1;
    bus.push_pc    = pc;
    bus.push_instr = instr;
    bus.push_excp  = excp;
  endtask

  task automatic idle();
    bus.push_valid = 1'b0;
    bus.push_pc    = '0;
    bus.push_instr = '0;
    bus.push_excp  = 1'b0;
  endtask

  // Expected entries enter the scoreboard on the edge where the push takes effect
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      occ = 0;
    end else begin
      if (bus.flush) begin
        exp_q.delete();
      end else if (bus.push_valid && occ < DEPTH) begin
        sb_e.pc    = bus.push_pc;
        sb_e.instr = bus.push_instr;
        sb_e.excp  = bus.push_excp;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!(occ == 0 && bus.pop_ready))
`endif
          exp_q.push_back(sb_e);
      end
      occ = exp_q.size();
    end
  end

  always @(negedge clk) begin
    if (rst && bus.pop_valid && bus.pop_ready) begin
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", bus.pop_pc, mon_e.pc);
        chk("sb_instr", bus.pop_instr, mon_e.instr);
        chk("sb_excp", {31'd0, bus.pop_excp}, {31'd0, mon_e.excp});
      end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("sb_bypass_pc", bus.pop_pc, bus.push_pc);
`else
        vec++;
        err++;
        $display("FAIL sb_underflow: pop of pc %h with no entry expected", bus.pop_pc);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.pop_ready = 1'b0;
    idle();
    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_pop_valid", bus.pop_valid, 0);
    chk("rst_afull", bus.almost_full, 0);
    chk("rst_pop_pc", bus.pop_pc, 0);
    chk("rst_push_ready", bus.push_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // three pushes while decode stalls
    for (int i = 0; i < 3; i++) begin
      push(RESET_PC + 32'(4 * i), 32'h24000000 + 32'(i), 1'b0);
      cyc();
      if (i == 0) chk("lat1_pop_pc", bus.pop_pc, RESET_PC);
      if (i == 1) chk("two_afull", bus.almost_full, 0);
    end
    idle();
    chk("three_count", bus.count, 3);
    chk("three_afull", bus.almost_full, 1);
    chk("three_pop_valid", bus.pop_valid, 1);
    chk("three_pop_instr", bus.pop_instr, 32'h24000000);
    cyc();
    chk("hold_pop_pc", bus.pop_pc, RESET_PC);

    // fill, hold push while full, pop once, then wrap
    push(32'hbfc0000c, 32'h2400000c, 1'b0);
    cyc();
    chk("full_count", bus.count, 4);
    chk("full_push_ready", bus.push_ready, 0);
    push(32'hbfc00010, 32'h24000010, 1'b0);
    cyc();
    chk("full_ignored_count", bus.count, 4);
    bus.pop_ready = 1'b1;
    cyc();
    bus.pop_ready = 1'b0;
    chk("full_pop_count", bus.count, 3);
    chk("full_pop_head", bus.pop_pc, 32'hbfc00004);
    cyc();
    idle();
    chk("refill_count", bus.count, 4);
    bus.pop_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) chk("wrap_head", bus.pop_pc, 32'hbfc00008 + 32'(4 * k));
    end
    bus.pop_ready = 1'b0;
    chk("drain_count", bus.count, 0);
    chk("drain_pop_valid", bus.pop_valid, 0);
    chk("drain_pop_pc", bus.pop_pc, 0);
    chk("drain_afull", bus.almost_full, 0);

    // steady push+pop at count 1
    push(32'h00001000, 32'h8c000000, 1'b0);
    cyc();
    bus.pop_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(32'h00001004 + 32'(4 * k), 32'h8c000001 + 32'(k), 1'b0);
      cyc();
      chk("stream_count", bus.count, 1);
      chk("stream_pop_pc", bus.pop_pc, 32'h00001004 + 32'(4 * k));
    end
    idle();
    cyc();
    bus.pop_ready = 1'b0;
    chk("stream_end_count", bus.count, 0);

    // flush with push and pop requested at count 3
    for (int i = 0; i < 3; i++) begin
      push(32'h00002000 + 32'(4 * i), 32'h10000000 + 32'(i), 1'b0);
      cyc();
    end
    bus.flush = 1'b1;
    push(32'h00002100, 32'h10000100, 1'b0);
    bus.pop_ready = 1'b1;
    #1;
    chk("flush_pop_valid", bus.pop_valid, 0);
    cyc();
    bus.flush     = 1'b0;
    bus.pop_ready = 1'b0;
    idle();
    chk("flush_count", bus.count, 0);
    chk("flush_afull", bus.almost_full, 0);
    push(32'h00003000, 32'h10003000, 1'b0);
    cyc();
    idle();
    chk("post_flush_head", bus.pop_pc, 32'h00003000);
    chk("post_flush_count", bus.count, 1);
    bus.pop_ready = 1'b1;
    cyc();
    bus.pop_ready = 1'b0;

    // exception tag rides with its entry only
    push(32'h00000001, 32'h00000000, 1'b1);
    cyc();
    push(32'h00004000, 32'h20000000, 1'b0);
    cyc();
    idle();
    chk("excp_first", {31'd0, bus.pop_excp}, 1);
    chk("excp_first_pc", bus.pop_pc, 32'h00000001);
    bus.pop_ready = 1'b1;
    cyc();
    chk("excp_second", {31'd0, bus.pop_excp}, 0);
    chk("excp_second_pc", bus.pop_pc, 32'h00004000);
    cyc();
    bus.pop_ready = 1'b0;
    chk("excp_count", bus.count, 0);

    // push into an empty queue with decode ready
    push(32'hbfc00380, 32'h42000018, 1'b0);
    bus.pop_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_pop_valid", bus.pop_valid, 1);
    chk("byp_pop_pc", bus.pop_pc, 32'hbfc00380);
    cyc();
    idle();
    bus.pop_ready = 1'b0;
    chk("byp_count", bus.count, 0);
`else
    chk("nobyp_pop_valid", bus.pop_valid, 0);
    cyc();
    idle();
    chk("nobyp_count", bus.count, 1);
    chk("nobyp_pop_pc", bus.pop_pc, 32'hbfc00380);
    cyc();
    bus.pop_ready = 1'b0;
    chk("nobyp_end_count", bus.count, 0);
`endif

    // asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      push(32'h00005000 + 32'(4 * i), 32'h30000000 + 32'(i), 1'b0);
      cyc();
    end
    push(32'h0000500c, 32'h3000000c, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_pop_valid", bus.pop_valid, 0);
    chk("arst_pop_pc", bus.pop_pc, 0);
    chk("arst_afull", bus.almost_full, 0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("arst_release_count", bus.count, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
